// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX (and future RX) datapaths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Full bit period in clocks from the half-bit divider setting.
    function automatic int bit_period(input int half);
        return 2 * half;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is read straight from storage.
// Latency: a word pushed at edge N is visible on dout / counted from edge N.
// Backpressure: push is ignored while full (even with a same-cycle pop); pop ignored while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed shifter, LSB first, optional parity, 1-2 stop bits.
// Latency: word accepted at edge N into an idle, empty block drives the start bit at edge N+1.
// Backpressure: in_ready drops only when the FIFO holds FIFO_DEPTH words.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [DATA_BITS-1:0]                in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                tx_busy,
    output logic                                txd
);

    localparam int T      = bit_period(CLK_PER_HALF_BIT);
    localparam int T_STOP = (T * 9) / 10;  // shortened final stop bit absorbs receiver skew
    localparam int TW     = $clog2(T);

    localparam logic [TW-1:0] BIT_END_CNT  = TW'(T - 1);
    localparam logic [TW-1:0] STOP_END_CNT = TW'(T_STOP - 1);
    localparam logic [3:0]    DATA_LAST    = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST    = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end

    uart_tx_state_t       state, state_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shifter, shifter_nxt;
    logic                 par, par_nxt;
    logic                 txd_nxt;
    logic                 load;
    logic                 pop;
    logic                 push;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 stop_end;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;
    assign bit_end  = (timer == BIT_END_CNT);
    assign stop_end = (timer == STOP_END_CNT);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next state, bit timing and serial data; a queued word is loaded from IDLE or straight
    // out of the final stop bit so consecutive frames have no idle gap. The parameter named
    // PARITY hides the enum literal, so that state is referenced through the package scope.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + TW'(1);
        bit_cnt_nxt = bit_cnt;
        shifter_nxt = shifter;
        par_nxt     = par;
        txd_nxt     = txd;
        load        = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                txd_nxt   = 1'b1;
                load      = ~fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    timer_nxt   = '0;
                    state_nxt   = DATA;
                    txd_nxt     = shifter[0];
                    par_nxt     = par ^ shifter[0];
                    shifter_nxt = shifter >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_nxt = '0;
                        if (PARITY != PAR_NONE) begin
                            state_nxt = uart_pkg::PARITY;
                            txd_nxt   = (PARITY == PAR_ODD) ? ~par : par;
                        end else begin
                            state_nxt = STOP;
                            txd_nxt   = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        txd_nxt     = shifter[0];
                        par_nxt     = par ^ shifter[0];
                        shifter_nxt = shifter >> 1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    state_nxt = STOP;
                    txd_nxt   = 1'b1;
                end
            end
            STOP: begin
                if (bit_cnt == STOP_LAST) begin
                    if (stop_end) begin
                        timer_nxt = '0;
                        state_nxt = IDLE;
                        txd_nxt   = 1'b1;
                        load      = ~fifo_empty;
                    end
                end else if (bit_end) begin
                    timer_nxt   = '0;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
        if (load) begin
            pop         = 1'b1;
            shifter_nxt = fifo_dout;
            par_nxt     = 1'b0;
            bit_cnt_nxt = '0;
            timer_nxt   = '0;
            txd_nxt     = 1'b0;
            state_nxt   = START;
        end
    end

    // State and datapath registers; busy tracks whether the FSM is leaving IDLE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shifter <= '0;
            par     <= 1'b0;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_cnt <= bit_cnt_nxt;
            shifter <= shifter_nxt;
            par     <= par_nxt;
            txd     <= txd_nxt;
            tx_busy <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five instances with T=8 clocks and a 4-deep FIFO.
// Instances: 0=8N1, 1=8E1, 2=8O1, 3=8N2, 4=5N1.
// Table of single-frame vectors plus hand sequences for back-to-back, fill and mid-frame reset.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int N = 5;

    function automatic int cfg_db(input int g);
        return (g == 4) ? 5 : 8;
    endfunction
    function automatic int cfg_par(input int g);
        return (g == 1) ? PAR_EVEN : ((g == 2) ? PAR_ODD : PAR_NONE);
    endfunction
    function automatic int cfg_stop(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] dat  [N];
    logic       vld  [N];
    logic       rdy  [N];
    logic [2:0] cnt  [N];
    logic       busy [N];
    logic       txd  [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int DB = cfg_db(g);
        uart_tx_fifo #(
            .CLK_PER_HALF_BIT (4),
            .DATA_BITS        (DB),
            .PARITY           (cfg_par(g)),
            .STOP_BITS        (cfg_stop(g)),
            .FIFO_DEPTH       (4)
        ) u_dut (
            .clk        (clk),
            .rstn       (rstn),
            .in_data    (dat[g][DB-1:0]),
            .in_valid   (vld[g]),
            .in_ready   (rdy[g]),
            .fifo_count (cnt[g]),
            .tx_busy    (busy[g]),
            .txd        (txd[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // bits: frame bits in transmit order from bit 0 (start bit first).
    typedef struct {
        int          k;
        logic [7:0]  data;
        logic [15:0] bits;
        int          nbits;
        int          frame;
        string       name;
    } vec_t;

    // Push one word into an idle instance and check latency, every bit centre and frame length.
    task automatic run_vec(input vec_t v);
        int k;
        int busy_clks;
        k = v.k;
        busy_clks = 0;
        @(negedge clk);
        dat[k] = v.data;
        vld[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[k] = 1'b0;
        chk({v.name, "_accept_txd"}, 32'(txd[k]), 1);
        chk({v.name, "_accept_busy"}, 32'(busy[k]), 0);
        chk({v.name, "_accept_cnt"}, 32'(cnt[k]), 1);
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk({v.name, "_start_busy"}, 32'(busy[k]), 1);
                chk({v.name, "_start_cnt"}, 32'(cnt[k]), 0);
            end
            if (!busy[k]) break;
            busy_clks++;
            if ((j % 8) == 4 && (j / 8) < v.nbits) begin
                chk($sformatf("%s_bit%0d", v.name, j / 8), 32'(txd[k]), 32'(v.bits[j / 8]));
            end
        end
        chk({v.name, "_frame_len"}, busy_clks, v.frame);
        chk({v.name, "_idle_txd"}, 32'(txd[k]), 1);
    endtask

    // Wait for a start bit on instance k and return the data byte sampled at bit centres.
    task automatic decode8(input int k, output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!txd[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            repeat (4) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (8) @(negedge clk);
                d[b] = txd[k];
            end
            repeat (8) @(negedge clk);
            chk("decode_stop", 32'(txd[k]), 1);
        end
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{0, 8'hA5, 16'({1'b1, 8'hA5, 1'b0}),       10, 79, "8n1_a5"};
        vecs[1] = '{1, 8'h07, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 87, "even_07"};
        vecs[2] = '{2, 8'h07, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 87, "odd_07"};
        vecs[3] = '{3, 8'h00, 16'({2'b11, 8'h00, 1'b0}),      11, 87, "2stop_00"};
        vecs[4] = '{4, 8'hFF, 16'({1'b1, 5'b11111, 1'b0}),    7,  55, "5bit_ff"};
        vecs[5] = '{1, 8'h81, 16'({1'b1, 1'b0, 8'h81, 1'b0}), 11, 87, "even_81"};
        vecs[6] = '{2, 8'h81, 16'({1'b1, 1'b1, 8'h81, 1'b0}), 11, 87, "odd_81"};

        rstn = 1'b0;
        for (int k = 0; k < N; k++) begin
            dat[k] = 8'h00;
            vld[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("reset_txd%0d", k), 32'(txd[k]), 1);
            chk($sformatf("reset_busy%0d", k), 32'(busy[k]), 0);
            chk($sformatf("reset_rdy%0d", k), 32'(rdy[k]), 1);
            chk($sformatf("reset_cnt%0d", k), 32'(cnt[k]), 0);
        end
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Two-stop back-to-back: 8+7 high clocks between frames, no idle gap, busy held.
        begin
            int first_high;
            int next_low;
            int fall;
            first_high = -1;
            next_low   = -1;
            fall       = -1;
            @(negedge clk);
            dat[3] = 8'h00;
            vld[3] = 1'b1;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            vld[3] = 1'b0;
            chk("b2b_push_pop_cnt", 32'(cnt[3]), 1);
            for (int j = 1; j < 250; j++) begin
                @(negedge clk);
                if (first_high < 0 && txd[3]) first_high = j;
                else if (first_high >= 0 && next_low < 0 && !txd[3]) next_low = j;
                if (!busy[3]) begin
                    fall = j;
                    break;
                end
            end
            chk("b2b_first_stop_start", first_high, 72);
            chk("b2b_high_gap", next_low - first_high, 15);
            chk("b2b_busy_len", fall, 174);
        end

        // Fill a 4-deep FIFO with in_valid held: 1 word goes to the shifter, 4 queue up.
        fork
            begin : writer
                int acc;
                bit got;
                acc = 0;
                got = 1'b0;
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    vld[0] = 1'b1;
                    dat[0] = 8'h10 + 8'(acc);
                    if (rdy[0]) acc++;
                end
                @(negedge clk);
                chk("fill_accepts", acc, 5);
                chk("fill_rdy_low", 32'(rdy[0]), 0);
                chk("fill_cnt", 32'(cnt[0]), 4);
                // At the pop edge in_ready is still low, so the held word is refused.
                for (int c = 0; c < 200; c++) begin
                    if (rdy[0]) begin
                        got = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                chk("fill_rdy_returns", 32'(got), 1);
                chk("full_pop_cnt", 32'(cnt[0]), 3);
                @(negedge clk);
                vld[0] = 1'b0;
                chk("refill_cnt", 32'(cnt[0]), 4);
            end
            begin : reader
                logic [7:0] d;
                bit ok;
                for (int f = 0; f < 6; f++) begin
                    decode8(0, d, ok);
                    chk($sformatf("fill_frame%0d_seen", f), 32'(ok), 1);
                    chk($sformatf("fill_frame%0d_data", f), 32'(d), 32'(8'h10 + 8'(f)));
                end
            end
        join

        // Reset in the middle of data bit 3 of 0xA5 (bit value 0) with a word still queued.
        repeat (100) @(negedge clk);
        dat[0] = 8'hA5;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dat[0] = 8'h66;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (35) @(negedge clk);
        chk("mid_bit3_txd", 32'(txd[0]), 0);
        chk("mid_busy", 32'(busy[0]), 1);
        chk("mid_cnt", 32'(cnt[0]), 1);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_txd", 32'(txd[0]), 1);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_cnt", 32'(cnt[0]), 0);
        chk("abort_rdy", 32'(rdy[0]), 1);
        rstn = 1'b1;
        begin
            vec_t v;
            v = '{0, 8'h3C, 16'({1'b1, 8'h3C, 1'b0}), 10, 79, "post_rst_3c"};
            run_vec(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
